// File: rtl/apb_controller_fsm.sv
// APB master FSM for the AHB-to-APB bridge: drives the APB setup and enable phases from the pipelined AHB signals.
// Latency: a read reaches APB setup 1 cycle after its address phase; a single write reaches setup 2 cycles after.
// Backpressure: hreadyout is low during each setup phase. With APB_PREADY_EN defined it is also low while an enable phase waits for pready.
// Optional feature macro: APB_PREADY_EN adds the pready input and stretches the enable phase until pready is high.
module apb_controller_fsm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwritereg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
`ifdef APB_PREADY_EN
  input  logic              pready,
`endif
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WWAIT    = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_WRITEP   = 3'd4;
  localparam logic [2:0] ST_RENABLE  = 3'd5;
  localparam logic [2:0] ST_WENABLE  = 3'd6;
  localparam logic [2:0] ST_WENABLEP = 3'd7;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic              in_enable;
  logic              en_hold;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Slave select from the address that is actually driven onto paddr.
  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
    logic [2:0] sel;
    sel = 3'b000;
    if (a >= ADDR_W'(32'h8000_0000) && a <= ADDR_W'(32'h83FF_FFFF))
      sel = 3'b001;
    else if (a >= ADDR_W'(32'h8400_0000) && a <= ADDR_W'(32'h87FF_FFFF))
      sel = 3'b010;
    else if (a >= ADDR_W'(32'h8800_0000) && a <= ADDR_W'(32'h8BFF_FFFF))
      sel = 3'b100;
    return sel;
  endfunction

  assign in_enable = (state == ST_RENABLE) || (state == ST_WENABLE) ||
                     (state == ST_WENABLEP);

`ifdef APB_PREADY_EN
  // An enable phase is stretched for as long as the slave holds pready low.
  assign en_hold = in_enable & ~pready;
`else
  assign en_hold = 1'b0;
`endif

  // A write setup that follows another write takes the address and data from one stage further back in the pipeline.
  always_comb begin
    wr_addr = haddr1;
    wr_data = hwdata;
    if (state == ST_WENABLEP) begin
      wr_addr = haddr2;
      wr_data = hwdata1;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    if (!en_hold) begin
      case (state)
        ST_IDLE: begin
          if (valid && !hwrite)     next_state = ST_READ;
          else if (valid && hwrite) next_state = ST_WWAIT;
          else                      next_state = ST_IDLE;
        end
        ST_WWAIT:    next_state = valid ? ST_WRITEP : ST_WRITE;
        ST_READ:     next_state = ST_RENABLE;
        ST_WRITE:    next_state = valid ? ST_WENABLEP : ST_WENABLE;
        ST_WRITEP:   next_state = ST_WENABLEP;
        ST_RENABLE, ST_WENABLE: begin
          if (!valid)       next_state = ST_IDLE;
          else if (!hwrite) next_state = ST_READ;
          else              next_state = ST_WWAIT;
        end
        ST_WENABLEP: begin
          if (!hwritereg) next_state = ST_READ;
          else if (valid) next_state = ST_WRITEP;
          else            next_state = ST_WRITE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // State register and registered APB/AHB outputs, loaded according to the state being entered.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      pselx     <= 3'b000;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state <= next_state;
      if (en_hold) begin
        hreadyout <= 1'b0;
      end else begin
        case (next_state)
          ST_READ: begin
            paddr     <= haddr;
            pwrite    <= 1'b0;
            penable   <= 1'b0;
            pselx     <= decode(haddr);
            hreadyout <= 1'b0;
          end
          ST_WRITE, ST_WRITEP: begin
            paddr     <= wr_addr;
            pwdata    <= wr_data;
            pwrite    <= 1'b1;
            penable   <= 1'b0;
            pselx     <= decode(wr_addr);
            hreadyout <= 1'b0;
          end
          ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
            penable   <= 1'b1;
            hreadyout <= 1'b1;
          end
          default: begin
            penable   <= 1'b0;
            pselx     <= 3'b000;
            hreadyout <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_controller_fsm.sv
// Directed bench for apb_controller_fsm; models the upstream one/two-cycle delay registers.
// Inputs change 1 time unit after the rising edge, and outputs are checked at that same point.
// Expected values are hand-derived for each cycle of each scenario.
module tb_apb_controller_fsm;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        valid = 1'b0;
  logic        hwrite = 1'b0;
  logic        hwritereg = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] haddr1 = '0;
  logic [31:0] haddr2 = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] hwdata1 = '0;
`ifdef APB_PREADY_EN
  logic        pready = 1'b1;
`endif
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hreadyout;

  int tests = 0;
  int fails = 0;

  apb_controller_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .hwrite    (hwrite),
    .hwritereg (hwritereg),
    .haddr     (haddr),
    .haddr1    (haddr1),
    .haddr2    (haddr2),
    .hwdata    (hwdata),
    .hwdata1   (hwdata1),
`ifdef APB_PREADY_EN
    .pready    (pready),
`endif
    .pwrite    (pwrite),
    .penable   (penable),
    .pselx     (pselx),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hreadyout (hreadyout)
  );

  always #5 hclk = ~hclk;

  // Upstream AHB slave interface pipeline registers.
  always @(posedge hclk) begin
    haddr1    <= haddr;
    haddr2    <= haddr1;
    hwdata1   <= hwdata;
    hwritereg <= hwrite;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_apb(input string tag, input logic [2:0] sel, input logic [31:0] addr,
                         input logic wr, input logic en, input logic rdy);
    chk({tag, ".pselx"}, 64'(pselx), 64'(sel));
    chk({tag, ".paddr"}, 64'(paddr), 64'(addr));
    chk({tag, ".pwrite"}, 64'(pwrite), 64'(wr));
    chk({tag, ".penable"}, 64'(penable), 64'(en));
    chk({tag, ".hreadyout"}, 64'(hreadyout), 64'(rdy));
  endtask

  // Drive one cycle of AHB-side inputs, then step past the next rising edge.
  task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    valid  = v;
    hwrite = w;
    haddr  = a;
    hwdata = d;
    @(posedge hclk);
    #1;
  endtask

  logic [31:0] dec_addr [4] = '{32'h83FF_FFFF, 32'h8BFF_FFFF, 32'h8C00_0000, 32'h7FFF_FFFF};
  logic [2:0]  dec_sel  [4] = '{3'b001, 3'b100, 3'b000, 3'b000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge hclk);
    #1;
    chk_apb("reset", 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset.pwdata", 64'(pwdata), 64'h0);
    hresetn = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("idle", 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);

    // Single read.
    cyc(1'b1, 1'b0, 32'h8400_0010, 32'h0);
    chk_apb("rd.setup", 3'b010, 32'h8400_0010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("rd.enable", 3'b010, 32'h8400_0010, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("rd.idle", 3'b000, 32'h8400_0010, 1'b0, 1'b0, 1'b1);

    // Single write.
    cyc(1'b1, 1'b1, 32'h8000_0004, 32'h0);
    chk_apb("wr.wwait", 3'b000, 32'h8400_0010, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    chk_apb("wr.setup", 3'b001, 32'h8000_0004, 1'b1, 1'b0, 1'b0);
    chk("wr.setup.pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 32'h0, 32'h0);
    chk_apb("wr.enable", 3'b001, 32'h8000_0004, 1'b1, 1'b1, 1'b1);
    chk("wr.enable.pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 32'h0, 32'h0);
    chk_apb("wr.idle", 3'b000, 32'h8000_0004, 1'b1, 1'b0, 1'b1);

    // Burst of three writes, master held while hreadyout is low.
    cyc(1'b1, 1'b1, 32'h8800_0000, 32'h0);
    chk_apb("bw.wwait", 3'b000, 32'h8000_0004, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'h8800_0004, 32'h1);
    chk_apb("bw.setup0", 3'b100, 32'h8800_0000, 1'b1, 1'b0, 1'b0);
    chk("bw.setup0.pwdata", 64'(pwdata), 64'h1);
    cyc(1'b1, 1'b1, 32'h8800_0008, 32'h2);
    chk_apb("bw.enable0", 3'b100, 32'h8800_0000, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 32'h8800_0008, 32'h2);
    chk_apb("bw.setup1", 3'b100, 32'h8800_0004, 1'b1, 1'b0, 1'b0);
    chk("bw.setup1.pwdata", 64'(pwdata), 64'h2);
    cyc(1'b0, 1'b1, 32'h0, 32'h3);
    chk_apb("bw.enable1", 3'b100, 32'h8800_0004, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 32'h3);
    chk_apb("bw.setup2", 3'b100, 32'h8800_0008, 1'b1, 1'b0, 1'b0);
    chk("bw.setup2.pwdata", 64'(pwdata), 64'h3);
    cyc(1'b0, 1'b1, 32'h0, 32'h0);
    chk_apb("bw.enable2", 3'b100, 32'h8800_0008, 1'b1, 1'b1, 1'b1);
    chk("bw.enable2.pwdata", 64'(pwdata), 64'h3);
    cyc(1'b0, 1'b1, 32'h0, 32'h0);
    chk_apb("bw.idle", 3'b000, 32'h8800_0008, 1'b1, 1'b0, 1'b1);

    // Write immediately followed by a read.
    cyc(1'b1, 1'b1, 32'h8000_0000, 32'h0);
    chk_apb("wr2rd.wwait", 3'b000, 32'h8800_0008, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h8400_0000, 32'h1234_5678);
    chk_apb("wr2rd.wsetup", 3'b001, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    chk("wr2rd.wsetup.pwdata", 64'(pwdata), 64'h1234_5678);
    cyc(1'b1, 1'b0, 32'h8400_0000, 32'h0);
    chk_apb("wr2rd.wenable", 3'b001, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 32'h8400_0000, 32'h0);
    chk_apb("wr2rd.rsetup", 3'b010, 32'h8400_0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("wr2rd.renable", 3'b010, 32'h8400_0000, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("wr2rd.idle", 3'b000, 32'h8400_0000, 1'b0, 1'b0, 1'b1);

    // Decode boundaries and unmapped addresses.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, dec_addr[i], 32'h0);
      chk_apb($sformatf("dec%0d.setup", i), dec_sel[i], dec_addr[i], 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk_apb($sformatf("dec%0d.enable", i), dec_sel[i], dec_addr[i], 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Asynchronous reset in the middle of a write setup.
    cyc(1'b1, 1'b1, 32'h8000_0008, 32'h0);
    cyc(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
    chk_apb("rst.pre", 3'b001, 32'h8000_0008, 1'b1, 1'b0, 1'b0);
    #2 hresetn = 1'b0;
    #1;
    chk_apb("rst.async", 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst.async.pwdata", 64'(pwdata), 64'h0);
    valid  = 1'b0;
    hwrite = 1'b0;
    @(posedge hclk);
    #1 hresetn = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("rst.after", 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h8800_0000, 32'h0);
    chk_apb("rst.rsetup", 3'b100, 32'h8800_0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("rst.ridle", 3'b000, 32'h8800_0000, 1'b0, 1'b0, 1'b1);

`ifdef APB_PREADY_EN
    // Read whose enable phase sees pready low for three cycles.
    cyc(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    chk_apb("prdy.setup", 3'b001, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    pready = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("prdy.enable", 3'b001, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk_apb($sformatf("prdy.wait%0d", i), 3'b001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    end
    pready = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk_apb("prdy.idle", 3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
